// File: rtl/niosdramproc_stepper_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// niosdramproc_stepper_pkg : register map, bit indices, phase table, FSM type
// Revision: 1.0
// ============================================================================
package niosdramproc_stepper_pkg;

    localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] c_ADDR_PERIOD = 3'd1;
    localparam logic [2:0] c_ADDR_STEPS  = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS = 3'd3;
    localparam logic [2:0] c_ADDR_POS    = 3'd4;

    localparam int c_CTRL_DIR    = 0;
    localparam int c_CTRL_HALF   = 1;
    localparam int c_CTRL_HOLD   = 2;
    localparam int c_CTRL_IRQ_EN = 3;

    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_DONE = 1;

    // Index 0 is the rightmost entry: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001
    localparam logic [7:0][3:0] c_PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [2:0] next_phase(input logic [2:0] ph,
                                              input logic       dir,
                                              input logic       half);
        logic [2:0] stride;
        stride = half ? 3'd1 : 3'd2;
        return dir ? (ph + stride) : (ph - stride);
    endfunction

endpackage
`default_nettype wire

// File: rtl/niosdramproc_stepper_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// niosdramproc_stepper_ctrl_if : Avalon-MM slave register bus
// Revision: 1.0
// ============================================================================
interface niosdramproc_stepper_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata);
endinterface
`default_nettype wire

// File: rtl/niosdramproc_step_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// niosdramproc_step_timer : loadable down-counter, one tick per PERIOD+1 clocks
// Revision: 1.0
// ============================================================================
module niosdramproc_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_load,
    input  wire logic                i_en,
    input  wire logic [PERIOD_W-1:0] i_period,
    output logic                     o_tick
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_period;
        end else if (i_en) begin
            // Reload samples the live period so rewrites apply at the next reload
            if (r_cnt == '0) r_cnt <= i_period;
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en && !i_load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/niosdramproc_stepper_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// niosdramproc_stepper_ctrl : Avalon-MM unipolar stepper sequencer
// Optional feature macro: STEPPER_IRQ_EN (level irq on DONE && IRQ_EN)
// Revision: 1.0
// ============================================================================
module niosdramproc_stepper_ctrl
    import niosdramproc_stepper_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16,
    parameter int POS_W    = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    niosdramproc_stepper_ctrl_if.slave bus,
    output logic [3:0]                out_port,
    output logic                      irq
);

`ifdef STEPPER_IRQ_EN
    localparam logic [3:0] c_CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] c_CTRL_MASK = 4'h7;
`endif

    state_t              r_state, w_state_next;
    logic [3:0]          r_ctrl;
    logic [PERIOD_W-1:0] r_period;
    logic [COUNT_W-1:0]  r_remaining, w_remaining_next;
    logic [POS_W-1:0]    r_pos, w_pos_next;
    logic [2:0]          r_phase, w_phase_next;
    logic                r_done, w_done_next;
    logic [3:0]          r_out;
    logic [31:0]         w_rdata;

    logic w_wr, w_wr_ctrl, w_wr_period, w_wr_steps, w_wr_status, w_wr_pos;
    logic w_steps_zero, w_start, w_abort, w_tick, w_step;
    logic w_unused;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wr_ctrl   = w_wr && (bus.address == c_ADDR_CTRL);
    assign w_wr_period = w_wr && (bus.address == c_ADDR_PERIOD);
    assign w_wr_steps  = w_wr && (bus.address == c_ADDR_STEPS);
    assign w_wr_status = w_wr && (bus.address == c_ADDR_STATUS);
    assign w_wr_pos    = w_wr && (bus.address == c_ADDR_POS);

    assign w_steps_zero = (bus.writedata[COUNT_W-1:0] == '0);
    assign w_start      = (r_state == ST_IDLE) && w_wr_steps && !w_steps_zero;
    // A zero STEPS write while running behaves exactly like the abort bit
    assign w_abort      = (r_state == ST_RUN) &&
                          ((w_wr_status && bus.writedata[c_STAT_BUSY]) ||
                           (w_wr_steps && w_steps_zero));
    assign w_step       = w_tick && !w_abort;
    assign w_unused     = ^bus.writedata;

    niosdramproc_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_start),
        .i_en     (r_state == ST_RUN),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_pos_next       = r_pos;
        w_remaining_next = r_remaining;
        w_done_next      = r_done;
        if (w_wr_status && bus.writedata[c_STAT_DONE]) w_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_pos) w_pos_next = bus.writedata[POS_W-1:0];
                if (w_start) begin
                    w_state_next     = ST_RUN;
                    w_remaining_next = bus.writedata[COUNT_W-1:0];
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_next     = ST_IDLE;
                    w_remaining_next = '0;
                end else begin
                    if (w_step) begin
                        w_phase_next     = next_phase(r_phase, r_ctrl[c_CTRL_DIR],
                                                      r_ctrl[c_CTRL_HALF]);
                        w_pos_next       = r_ctrl[c_CTRL_DIR] ? r_pos + 1'b1
                                                              : r_pos - 1'b1;
                        w_remaining_next = r_remaining - 1'b1;
                    end
                    if (w_wr_steps) begin
                        w_remaining_next = bus.writedata[COUNT_W-1:0];
                    end else if (w_step && (r_remaining == COUNT_W'(1))) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl      <= '0;
            r_period    <= '0;
            r_remaining <= '0;
            r_pos       <= '0;
            r_phase     <= '0;
            r_done      <= 1'b0;
            r_out       <= '0;
        end else begin
            r_remaining <= w_remaining_next;
            r_pos       <= w_pos_next;
            r_phase     <= w_phase_next;
            r_done      <= w_done_next;
            // Completing step still shows its pattern for one clock before release
            r_out       <= ((r_state == ST_RUN) || r_ctrl[c_CTRL_HOLD])
                           ? c_PHASE_TABLE[w_phase_next] : 4'b0000;
            if (w_wr_ctrl)   r_ctrl   <= bus.writedata[3:0] & c_CTRL_MASK;
            if (w_wr_period) r_period <= bus.writedata[PERIOD_W-1:0];
        end
    end

    assign out_port = r_out;

`ifdef STEPPER_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= r_done && r_ctrl[c_CTRL_IRQ_EN];
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            c_ADDR_CTRL:   w_rdata[3:0]          = r_ctrl;
            c_ADDR_PERIOD: w_rdata[PERIOD_W-1:0] = r_period;
            c_ADDR_STEPS:  w_rdata[COUNT_W-1:0]  = r_remaining;
            c_ADDR_STATUS: begin
                w_rdata[c_STAT_BUSY] = (r_state == ST_RUN);
                w_rdata[c_STAT_DONE] = r_done;
            end
            c_ADDR_POS:    w_rdata[POS_W-1:0]    = r_pos;
            default:       w_rdata               = '0;
        endcase
    end

    assign bus.readdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_niosdramproc_stepper_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_niosdramproc_stepper_ctrl : self-checking bench for the stepper sequencer
// Revision: 1.0
// ============================================================================
module tb_niosdramproc_stepper_ctrl;

    localparam logic [2:0] A_CTRL = 3'd0, A_PERIOD = 3'd1, A_STEPS = 3'd2,
                           A_STATUS = 3'd3, A_POS = 3'd4;
`ifdef STEPPER_IRQ_EN
    localparam logic [31:0] CTRL_B_EXP = 32'hB;
`else
    localparam logic [31:0] CTRL_B_EXP = 32'h3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out_port;
    logic       irq;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};
    int         m_phase = 0;
    int         m_pos = 0;

    niosdramproc_stepper_ctrl_if bus();

    niosdramproc_stepper_ctrl #(
        .PERIOD_W (16),
        .COUNT_W  (16),
        .POS_W    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [19];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_phase = 0;
        m_pos = 0;
    endtask

    // Model: step k lands k*(P+1) clocks after the STEPS write; the pattern
    // is driven while running and for the completing clock, else only with HOLD.
    task automatic run_move(input logic [3:0] ctrl, input int period, input int n);
        int stride, total, sd, ph;
        logic [31:0] d;
        logic [3:0]  eo;
        stride = ctrl[1] ? 1 : 2;
        if (!ctrl[0]) stride = -stride;
        total = n * (period + 1);
        wr(A_CTRL, {28'd0, ctrl});
        wr(A_PERIOD, period);
        wr(A_STEPS, n);
        for (int c = 0; c <= total + 2; c++) begin
            sd = (c / (period + 1) < n) ? c / (period + 1) : n;
            ph = ((m_phase + stride * sd) % 8 + 8) % 8;
            eo = (((c >= 1) && (c <= total)) || ctrl[2]) ? tbl[ph] : 4'b0000;
            chk($sformatf("out_port c=%0d", c), {28'd0, out_port}, {28'd0, eo});
            rd(A_STATUS, d);
            chk($sformatf("busy c=%0d", c), {31'd0, d[0]}, {31'd0, (c < total)});
            @(negedge clk);
        end
        m_phase = ((m_phase + stride * n) % 8 + 8) % 8;
        m_pos   = m_pos + (ctrl[0] ? n : -n);
        rd(A_POS, d);    chk("pos_after_move", d, m_pos & 32'hFFFF);
        rd(A_STEPS, d);  chk("steps_after_move", d, 32'd0);
        rd(A_STATUS, d); chk("status_after_move", d, 32'h2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 3'(i), 32'h0, 32'h0};
        vecs[8]  = '{1'b1, A_CTRL,   32'hFFFF_FFF4, 32'h4};
        vecs[9]  = '{1'b1, A_CTRL,   32'h0000_000B, CTRL_B_EXP};
        vecs[10] = '{1'b1, A_PERIOD, 32'hABCD_1234, 32'h1234};
        vecs[11] = '{1'b1, A_POS,    32'h8000_FFFE, 32'hFFFE};
        vecs[12] = '{1'b1, 3'd5,     32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b1, 3'd7,     32'hFFFF_FFFF, 32'h0};
        vecs[14] = '{1'b1, A_STEPS,  32'h0,         32'h0};
        vecs[15] = '{1'b1, A_STATUS, 32'h3,         32'h0};
        vecs[16] = '{1'b1, A_CTRL,   32'h0,         32'h0};
        vecs[17] = '{1'b1, A_PERIOD, 32'h0,         32'h0};
        vecs[18] = '{1'b1, A_POS,    32'h0,         32'h0};

        do_reset();
        chk("reset_out_port", {28'd0, out_port}, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            else            @(negedge clk);
            rd(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        rd(A_STATUS, d); chk("steps0_no_motion", d, 32'h0);
        chk("idle_out_port", {28'd0, out_port}, 32'h0);

        // Forward half-step, 5-clock spacing
        do_reset();
        run_move(4'h3, 4, 3);
        rd(A_POS, d);    chk("t1_pos", d, 32'h3);
        rd(A_STATUS, d); chk("t1_status", d, 32'h2);
`ifndef STEPPER_IRQ_EN
        wr(A_CTRL, 32'hB);
        @(negedge clk);
        chk("irq_tied_low", {31'd0, irq}, 32'h0);
`endif

        // Reverse full-step with hold, one step per clock
        do_reset();
        run_move(4'h4, 0, 4);
        rd(A_POS, d); chk("t2_pos", d, 32'hFFFC);
        chk("t2_hold_out", {28'd0, out_port}, 32'h1);

        // Abort after 25 clocks at PERIOD 9
        do_reset();
        wr(A_CTRL, 32'h1);
        wr(A_PERIOD, 32'd9);
        wr(A_STEPS, 32'd100);
        repeat (24) @(negedge clk);
        wr(A_STATUS, 32'h1);
        @(negedge clk);
        rd(A_STEPS, d);  chk("abort_steps", d, 32'h0);
        rd(A_STATUS, d); chk("abort_status", d, 32'h0);
        rd(A_POS, d);    chk("abort_pos", d, 32'h2);
        chk("abort_out", {28'd0, out_port}, 32'h0);

        // STEPS reload while busy does not restart the divider
        do_reset();
        wr(A_CTRL, 32'h1);
        wr(A_PERIOD, 32'd3);
        wr(A_STEPS, 32'd5);
        repeat (6) @(negedge clk);
        wr(A_STEPS, 32'd2);
        rd(A_STEPS, d);  chk("reload_steps", d, 32'h2);
        repeat (10) @(negedge clk);
        rd(A_POS, d);    chk("reload_pos", d, 32'h3);
        rd(A_STATUS, d); chk("reload_status", d, 32'h2);

`ifdef STEPPER_IRQ_EN
        do_reset();
        wr(A_CTRL, 32'h9);
        wr(A_PERIOD, 32'd0);
        wr(A_STEPS, 32'd1);
        chk("irq_low_start", {31'd0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        chk("irq_high", {31'd0, irq}, 32'h1);
        wr(A_STATUS, 32'h2);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        rd(A_STATUS, d); chk("irq_done_cleared", d, 32'h0);
        wr(A_PERIOD, 32'd2);
        wr(A_STEPS, 32'd1);
        repeat (2) @(negedge clk);
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, d); chk("done_set_wins", d, 32'h2);
        @(negedge clk);
        chk("irq_after_set_wins", {31'd0, irq}, 32'h1);
`endif

        // Reset mid-motion; POS writes while busy are ignored
        do_reset();
        wr(A_POS, 32'd7);
        wr(A_CTRL, 32'h1);
        wr(A_PERIOD, 32'd3);
        wr(A_STEPS, 32'd10);
        @(negedge clk);
        wr(A_POS, 32'h55);
        rd(A_POS, d);    chk("pos_write_busy", d, 32'h7);
        repeat (3) @(negedge clk);
        rd(A_POS, d);    chk("pos_after_step", d, 32'h8);
        rd(A_STATUS, d); chk("busy_before_reset", d, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        rd(A_STATUS, d); chk("rst_status", d, 32'h0);
        rd(A_POS, d);    chk("rst_pos", d, 32'h0);
        chk("rst_out", {28'd0, out_port}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;

        // Randomized moves against the model
        do_reset();
        for (int k = 0; k < 12; k++) begin
            run_move(4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                     int'($urandom_range(1, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
